gemm_tile_reader: RTL and testbench
===================================

GEMM_TILE_READER -- requirements
Module: gemm_tile_reader

Interface
REQ-001 Parameter DataWidth, default 64, TCDM word width in bits.
REQ-002 Parameter BeatsPerTile, default 8, words per 512-bit tile (8x8 int8).
REQ-003 clk_i  input  1  single clock; all state rising-edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 gemm_read_i  input  1  one-cycle tile-fetch request from the GEMM controller.
REQ-006 addr_a_i  input  32  A tile base byte address, sampled with gemm_read_i.
REQ-007 addr_b_i  input  32  B tile base byte address, sampled with gemm_read_i.
REQ-008 tcdm_req_valid_o  output  1  read request valid.
REQ-009 tcdm_req_ready_i  input  1  request accepted when both valid and ready are high.
REQ-010 tcdm_req_addr_o  output  32  request byte address.
REQ-011 tcdm_rsp_valid_i  input  1  read data valid; responses return in request order, latency >=1 cycle.
REQ-012 tcdm_rsp_data_i  input  DataWidth  read data.
REQ-013 a_tile_o  output  DataWidth*BeatsPerTile  assembled A tile, beat k in bits [k*DataWidth +: DataWidth].
REQ-014 b_tile_o  output  DataWidth*BeatsPerTile  assembled B tile, same packing.
REQ-015 tile_valid_o  output  1  both tiles complete.
REQ-016 tile_ready_i  input  1  GEMM array consumes tiles when valid and ready are high.
REQ-017 busy_o  output  1  high in any state except IDLE.
REQ-018 overflow_o  output  1  sticky: a request was dropped.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, OUT.
REQ-020 IDLE: gemm_read_i latches addr_a_i/addr_b_i into active registers; next state REQ.
REQ-021 REQ: tcdm_req_valid_o=1; beat index i from 0 to 2*BeatsPerTile-1; address = addr_a+8*i for i<8, else addr_b+8*(i-8); i advances only on handshake.
REQ-022 REQ: after handshake of the last beat (i=15), next state WAIT; a request stalled by low tcdm_req_ready_i keeps valid and address stable.
REQ-023 Response counter r, 0..15, increments on each tcdm_rsp_valid_i; beat r<8 written to A word r, else to B word r-8; responses are accepted in both REQ and WAIT.
REQ-024 Responses may overlap with request issue; the FSM enters OUT on the cycle after response 15 is captured, whether that occurs in REQ or WAIT.
REQ-025 OUT: tile_valid_o=1; tile outputs are held stable until the tile_valid_o/tile_ready_i handshake.
REQ-026 On OUT handshake: pending entry valid -> load it as active, clear pending, go to REQ; else go to IDLE.
REQ-027 Pending buffer has one entry; gemm_read_i outside IDLE is stored in pending if it is empty.
REQ-028 gemm_read_i outside IDLE with pending full: request is dropped, overflow_o is set, and overflow_o stays high until reset.
REQ-029 gemm_read_i coincident with the OUT handshake and pending empty: the request becomes active directly, next state REQ.
REQ-030 tcdm_rsp_valid_i in IDLE or OUT is ignored and does not change any state.
REQ-031 Latency: gemm_read_i in IDLE, ready=1, response latency 1 -> tile_valid_o asserts 18 cycles after the request.
REQ-032 Address arithmetic is 32-bit unsigned with wrap-around and no error.

Reset
REQ-033 rst_i asserted at any time, including mid-fetch: FSM=IDLE, counters=0, pending cleared, overflow_o=0, tile registers=0.
REQ-034 Reset values: tcdm_req_valid_o=0, tcdm_req_addr_o=0, tile_valid_o=0, busy_o=0, a_tile_o=0, b_tile_o=0.
REQ-035 In-flight responses after reset release are ignored in IDLE.

Structure
REQ-036 Package gemm_pkg holds the FSM state enum, DataWidth, BeatsPerTile and the tile size constants (512 bits for A/B, 2048 bits for C).
REQ-037 One sub-module, gemm_req_fifo: a 1-entry address buffer with valid flag, used for the pending request.

Verification
REQ-038 Single request, A=0x1000, B=0x2000, ready=1, latency 1 -> addresses 0x1000..0x1038 then 0x2000..0x2038; tile_valid_o after 18 cycles; data matches.
REQ-039 Random tcdm_req_ready_i stalls (50%) -> address held during stall, no beat skipped or duplicated, tiles correct.
REQ-040 Three gemm_read_i pulses during a fetch -> second stored in pending, third sets overflow_o; two tiles delivered in order.
REQ-041 tile_ready_i low for 10 cycles in OUT -> outputs stable; gemm_read_i on the handshake cycle starts a new fetch the next cycle.
REQ-042 rst_i pulse at beat 5 of A -> all outputs return to reset values immediately; a later request is fetched cleanly.
REQ-043 Response latency 4 with back-to-back grants -> all 16 responses captured in order, WAIT entered before OUT.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared constants and types for the GEMM tile reader: FSM encoding,
// TCDM word geometry and the tile-request record held in the pending buffer.
package gemm_pkg;

    localparam int DataWidth    = 64;
    localparam int BeatsPerTile = 8;
    localparam int AddrWidth    = 32;
    localparam int AbTileBits   = 512;
    localparam int CTileBits    = 2048;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StOut
    } state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr_a;
        logic [AddrWidth-1:0] addr_b;
    } tile_req_t;

endpackage

// File: rtl/gemm_tile_reader_if.sv
// TCDM read port: request channel with valid/ready and an in-order response
// channel with valid only.
interface gemm_tile_reader_if #(
    parameter int DataWidth = gemm_pkg::DataWidth
);
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 rsp_valid;
    logic [DataWidth-1:0] rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/gemm_req_fifo.sv
// Single-entry holding buffer for a tile request that arrives while a fetch
// is already in progress.
module gemm_req_fifo
    import gemm_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  tile_req_t data_i,
    output logic      valid_o,
    output tile_req_t data_o
);

    logic      valid_q, valid_d;
    tile_req_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (pop_i) begin
            valid_d = 1'b0;
        end
        // A push into a full entry is ignored; the owner flags the loss.
        if (push_i && !valid_q) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/gemm_tile_reader.sv
// Fetches one A and one B tile from TCDM as 2*BeatsPerTile word reads,
// assembles them and hands both to the GEMM array with a valid/ready pair.
module gemm_tile_reader #(
    parameter int DataWidth    = gemm_pkg::DataWidth,
    parameter int BeatsPerTile = gemm_pkg::BeatsPerTile
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              gemm_read_i,
    input  logic [31:0]                       addr_a_i,
    input  logic [31:0]                       addr_b_i,
    gemm_tile_reader_if.master                tcdm,
    output logic [DataWidth*BeatsPerTile-1:0] a_tile_o,
    output logic [DataWidth*BeatsPerTile-1:0] b_tile_o,
    output logic                              tile_valid_o,
    input  logic                              tile_ready_i,
    output logic                              busy_o,
    output logic                              overflow_o
);
    import gemm_pkg::*;

    localparam int BeatW     = $clog2(BeatsPerTile);
    localparam int IdxW      = BeatW + 1;
    localparam int ByteShift = $clog2(DataWidth / 8);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(2 * BeatsPerTile - 1);

    state_e                                 state_q, state_d;
    tile_req_t                              act_q, act_d;
    logic [IdxW-1:0]                        req_idx_q, req_idx_d;
    logic [IdxW-1:0]                        rsp_idx_q, rsp_idx_d;
    logic [BeatsPerTile-1:0][DataWidth-1:0] a_tile_q, a_tile_d;
    logic [BeatsPerTile-1:0][DataWidth-1:0] b_tile_q, b_tile_d;
    logic                                   ovf_q, ovf_d;

    logic      req_hs, rsp_take, rsp_last, out_hs;
    logic      pend_valid, pend_push, pend_pop;
    tile_req_t pend_req, new_req;
    logic [31:0] beat_base, beat_off;

    assign new_req  = '{addr_a: addr_a_i, addr_b: addr_b_i};
    assign req_hs   = (state_q == StReq) && tcdm.req_ready;
    assign rsp_take = tcdm.rsp_valid && ((state_q == StReq) || (state_q == StWait));
    assign rsp_last = rsp_take && (rsp_idx_q == LastIdx);
    assign out_hs   = (state_q == StOut) && tile_ready_i;

    // On the output handshake a fresh request bypasses the buffer.
    assign pend_pop  = out_hs && pend_valid;
    assign pend_push = gemm_read_i && (state_q != StIdle) && !pend_valid && !out_hs;

    gemm_req_fifo u_pend (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pend_push),
        .pop_i   (pend_pop),
        .data_i  (new_req),
        .valid_o (pend_valid),
        .data_o  (pend_req)
    );

    // Upper index bit selects the B tile; lower bits are the word offset.
    assign beat_base = req_idx_q[IdxW-1] ? act_q.addr_b : act_q.addr_a;
    assign beat_off  = 32'(req_idx_q[BeatW-1:0]) << ByteShift;

    assign tcdm.req_valid = (state_q == StReq);
    assign tcdm.req_addr  = (state_q == StReq) ? beat_base + beat_off : '0;

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        req_idx_d = req_idx_q;
        rsp_idx_d = rsp_idx_q;
        a_tile_d  = a_tile_q;
        b_tile_d  = b_tile_q;
        ovf_d     = ovf_q | (gemm_read_i && (state_q != StIdle) && pend_valid);

        if (req_hs) begin
            req_idx_d = req_idx_q + 1'b1;
        end
        if (rsp_take) begin
            rsp_idx_d = rsp_idx_q + 1'b1;
            if (!rsp_idx_q[IdxW-1]) begin
                a_tile_d[rsp_idx_q[BeatW-1:0]] = tcdm.rsp_data;
            end else begin
                b_tile_d[rsp_idx_q[BeatW-1:0]] = tcdm.rsp_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (gemm_read_i) begin
                    act_d     = new_req;
                    req_idx_d = '0;
                    rsp_idx_d = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (rsp_last) begin
                    state_d = StOut;
                end else if (req_hs && (req_idx_q == LastIdx)) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rsp_last) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (tile_ready_i) begin
                    req_idx_d = '0;
                    rsp_idx_d = '0;
                    if (pend_valid) begin
                        act_d   = pend_req;
                        state_d = StReq;
                    end else if (gemm_read_i) begin
                        act_d   = new_req;
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            act_q     <= '0;
            req_idx_q <= '0;
            rsp_idx_q <= '0;
            a_tile_q  <= '0;
            b_tile_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            req_idx_q <= req_idx_d;
            rsp_idx_q <= rsp_idx_d;
            a_tile_q  <= a_tile_d;
            b_tile_q  <= b_tile_d;
            ovf_q     <= ovf_d;
        end
    end

    assign a_tile_o     = a_tile_q;
    assign b_tile_o     = b_tile_q;
    assign tile_valid_o = (state_q == StOut);
    assign busy_o       = (state_q != StIdle);
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_gemm_tile_reader.sv
// Directed bench for gemm_tile_reader with a TCDM memory model of
// configurable response latency and optional random request back-pressure.
module tb_gemm_tile_reader;

    localparam int DW  = 64;
    localparam int BPT = 8;
    localparam int TW  = DW * BPT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gemm_read = 1'b0;
    logic          tile_ready = 1'b0;
    logic [31:0]   addr_a = '0;
    logic [31:0]   addr_b = '0;
    logic [TW-1:0] a_tile, b_tile;
    logic          tile_valid, busy, overflow;

    gemm_tile_reader_if #(.DataWidth(DW)) tcdm ();

    gemm_tile_reader #(.DataWidth(DW), .BeatsPerTile(BPT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .gemm_read_i  (gemm_read),
        .addr_a_i     (addr_a),
        .addr_b_i     (addr_b),
        .tcdm         (tcdm),
        .a_tile_o     (a_tile),
        .b_tile_o     (b_tile),
        .tile_valid_o (tile_valid),
        .tile_ready_i (tile_ready),
        .busy_o       (busy),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // Memory model: accepted requests travel down a delay line of depth lat.
    int          lat = 1;
    logic        stall_en = 1'b0;
    logic        ready = 1'b1;
    logic        hs_n = 1'b0;
    logic [31:0] hs_addr_n = '0;
    logic [7:0]  pv = '0;
    logic [31:0] pa [8];

    always @(posedge clk) begin
        pv    <= {pv[6:0], hs_n};
        pa[0] <= hs_addr_n;
        for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end

    assign tcdm.req_ready = ready;
    assign tcdm.rsp_valid = pv[lat-1];
    assign tcdm.rsp_data  = mem_data(pa[lat-1]);

    initial forever begin
        @(posedge clk);
        #1;
        ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: logs accepted addresses, checks stall stability, spots WAIT.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        saw_wait = 1'b0;
    logic [31:0] got_addr [$];

    initial forever begin
        @(negedge clk);
        if (prev_stall)
            chk("stall_hold", TW'({tcdm.req_valid, tcdm.req_addr}), TW'({1'b1, prev_addr}));
        hs_n      = tcdm.req_valid && tcdm.req_ready;
        hs_addr_n = tcdm.req_addr;
        if (hs_n) got_addr.push_back(tcdm.req_addr);
        prev_stall = tcdm.req_valid && !tcdm.req_ready && !rst;
        prev_addr  = tcdm.req_addr;
        if (busy && !tcdm.req_valid && !tile_valid) saw_wait = 1'b1;
    end

    task automatic pulse_read(input logic [31:0] a, input logic [31:0] b);
        addr_a    = a;
        addr_b    = b;
        gemm_read = 1'b1;
        @(posedge clk);
        #1 gemm_read = 1'b0;
    endtask

    task automatic wait_tile(output int cyc);
        cyc = 0;
        while (!tile_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!tile_valid) chk("tile_timeout", TW'(tile_valid), TW'(1));
    endtask

    task automatic consume();
        tile_ready = 1'b1;
        @(posedge clk);
        #1 tile_ready = 1'b0;
    endtask

    task automatic check_tile(input logic [31:0] a, input logic [31:0] b);
        logic [TW-1:0] ea, eb;
        logic [31:0]   ad;
        for (int k = 0; k < BPT; k++) begin
            ea[k*DW +: DW] = mem_data(a + 32'(k * 8));
            eb[k*DW +: DW] = mem_data(b + 32'(k * 8));
        end
        chk("a_tile", a_tile, ea);
        chk("b_tile", b_tile, eb);
        for (int i = 0; i < 2 * BPT; i++) begin
            ad = (i < BPT) ? a + 32'(8 * i) : b + 32'(8 * (i - BPT));
            if (got_addr.size() == 0) chk("addr_missing", TW'(got_addr.size()), TW'(1));
            else chk("addr_seq", TW'(got_addr.pop_front()), TW'(ad));
        end
        chk("addr_extra", TW'(got_addr.size()), TW'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          stable;
        logic        found;
        logic [TW-1:0] sa, sb;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", TW'(tcdm.req_valid), TW'(0));
        chk("rst_req_addr", TW'(tcdm.req_addr), TW'(0));
        chk("rst_tile_valid", TW'(tile_valid), TW'(0));
        chk("rst_busy", TW'(busy), TW'(0));
        chk("rst_ovf", TW'(overflow), TW'(0));
        chk("rst_a_tile", a_tile, TW'(0));
        chk("rst_b_tile", b_tile, TW'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, no stalls, latency 1.
        pulse_read(32'h0000_1000, 32'h0000_2000);
        chk("t1_busy", TW'(busy), TW'(1));
        wait_tile(cyc);
        chk("t1_latency", TW'(cyc), TW'(18));
        check_tile(32'h0000_1000, 32'h0000_2000);
        consume();
        @(negedge clk);
        chk("t1_idle", TW'(busy), TW'(0));

        // Random back-pressure, addresses wrap past 2^32.
        stall_en = 1'b1;
        pulse_read(32'hFFFF_FFE0, 32'h0000_0040);
        wait_tile(cyc);
        check_tile(32'hFFFF_FFE0, 32'h0000_0040);
        stall_en = 1'b0;
        consume();
        repeat (8) @(negedge clk);

        // Pending buffer and overflow.
        lat = 2;
        pulse_read(32'h0001_0000, 32'h0002_0000);
        repeat (3) @(negedge clk);
        pulse_read(32'h0000_3000, 32'h0000_4000);
        @(negedge clk);
        chk("t3_ovf_clear", TW'(overflow), TW'(0));
        pulse_read(32'h0000_5000, 32'h0000_6000);
        @(negedge clk);
        chk("t3_ovf_set", TW'(overflow), TW'(1));
        wait_tile(cyc);
        check_tile(32'h0001_0000, 32'h0002_0000);
        consume();
        wait_tile(cyc);
        check_tile(32'h0000_3000, 32'h0000_4000);
        consume();
        @(negedge clk);
        chk("t3_idle", TW'(busy), TW'(0));
        chk("t3_ovf_sticky", TW'(overflow), TW'(1));

        // Output held under back-pressure; new request on the handshake.
        pulse_read(32'h0000_8000, 32'h0000_9000);
        wait_tile(cyc);
        sa = a_tile;
        sb = b_tile;
        stable = 0;
        repeat (10) begin
            @(negedge clk);
            if (tile_valid && a_tile === sa && b_tile === sb) stable++;
        end
        chk("t4_hold", TW'(stable), TW'(10));
        check_tile(32'h0000_8000, 32'h0000_9000);
        addr_a     = 32'h0000_A000;
        addr_b     = 32'h0000_B000;
        gemm_read  = 1'b1;
        tile_ready = 1'b1;
        @(posedge clk);
        #1;
        gemm_read  = 1'b0;
        tile_ready = 1'b0;
        @(negedge clk);
        chk("t4_next_valid", TW'(tcdm.req_valid), TW'(1));
        chk("t4_next_addr", TW'(tcdm.req_addr), TW'(32'h0000_A000));
        chk("t4_tv_drop", TW'(tile_valid), TW'(0));
        wait_tile(cyc);
        check_tile(32'h0000_A000, 32'h0000_B000);
        consume();
        repeat (8) @(negedge clk);

        // Reset mid-fetch at beat 5 of A.
        lat = 1;
        pulse_read(32'h0000_C000, 32'h0000_D000);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (tcdm.req_valid && tcdm.req_addr == 32'h0000_C028) found = 1'b1;
        end
        chk("t5_beat5_seen", TW'(found), TW'(1));
        rst = 1'b1;
        #1;
        chk("t5_req_valid", TW'(tcdm.req_valid), TW'(0));
        chk("t5_req_addr", TW'(tcdm.req_addr), TW'(0));
        chk("t5_tile_valid", TW'(tile_valid), TW'(0));
        chk("t5_busy", TW'(busy), TW'(0));
        chk("t5_ovf", TW'(overflow), TW'(0));
        chk("t5_a_tile", a_tile, TW'(0));
        chk("t5_b_tile", b_tile, TW'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_post_busy", TW'(busy), TW'(0));
        chk("t5_post_a_tile", a_tile, TW'(0));
        got_addr.delete();
        repeat (8) @(negedge clk);

        // Latency 4, back-to-back grants: WAIT precedes OUT.
        lat = 4;
        saw_wait = 1'b0;
        pulse_read(32'h0010_0000, 32'h0020_0000);
        wait_tile(cyc);
        chk("t6_latency", TW'(cyc), TW'(21));
        chk("t6_wait_seen", TW'(saw_wait), TW'(1));
        check_tile(32'h0010_0000, 32'h0020_0000);
        consume();
        @(negedge clk);
        chk("t6_idle", TW'(busy), TW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
